// File: rtl/fmul_q16.sv
// Iterative signed WxW shift-add multiplier, full 2W-bit Q32.32 product.
// Define FMUL_Q16_ROUND_EN to add a round-to-nearest bias of 2^(W/2-1).
module fmul_q16 #(
  parameter int W = 32
) (
  input  logic           c,
  input  logic           r_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int CW = $clog2(W);

`ifdef FMUL_Q16_ROUND_EN
  localparam logic [2*W-1:0] BIAS = (2*W)'(1) << (W/2-1);
`else
  localparam logic [2*W-1:0] BIAS = '0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q;
  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] p_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_q;

  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] acc_d;
  logic [2*W-1:0] p_d;

  // -2^(W-1) negates to itself, which reads correctly as unsigned
  assign mag_a = a[W-1] ? -a : a;
  assign mag_b = b[W-1] ? -b : b;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
    p_d = (sign_q ? -acc_d : acc_d) + BIAS;
  end

  always_ff @(posedge c or negedge r_n) begin
    if (!r_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= {{W{1'b0}}, mag_a};
            mplier_q <= mag_b;
            sign_q   <= a[W-1] ^ b[W-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            p_q     <= p_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_fmul_q16.sv
// Directed self-checking bench for fmul_q16.
// Expected products carry the rounding bias when FMUL_Q16_ROUND_EN is set.
module tb_fmul_q16;

`ifdef FMUL_Q16_ROUND_EN
  localparam logic [63:0] BIAS = 64'h0000_0000_0000_8000;
`else
  localparam logic [63:0] BIAS = 64'h0;
`endif

  logic        c;
  logic        r_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;

  int n_checks;
  int n_fail;

  fmul_q16 #(.W(32)) dut (
    .c        (c),
    .r_n      (r_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  // Drive one accept, then wait (bounded) for out_valid.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [63:0] gp, output int lat);
    @(negedge c);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge c);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      @(posedge c);
      #1;
      lat++;
    end
    gp = p;
  endtask

  task automatic finish_op;
    @(posedge c);
    #1;
  endtask

  task automatic test_reset;
    r_n       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_checks++;
    if (p !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_p got %h want 0", p);
    end
    repeat (2) @(negedge c);
    r_n = 1'b1;
  endtask

  task automatic test_unity;
    logic [63:0] gp;
    int lat;
    out_ready = 1'b1;
    run_op(32'h0001_0000, 32'h0001_0000, gp, lat);
    n_checks++;
    if (gp !== 64'h0000_0001_0000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL unity_p got %h want %h", gp,
               64'h0000_0001_0000_0000 + BIAS);
    end
    n_checks++;
    if (lat != 32) begin
      n_fail++;
      $display("FAIL unity_latency got %0d want 32", lat);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL unity_in_ready_done got %b want 0", in_ready);
    end
    finish_op();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL unity_handshake in_ready %b out_valid %b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_signed;
    logic [63:0] gp;
    int lat;
    out_ready = 1'b1;
    run_op(32'hFFFE_8000, 32'h0002_0000, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== 64'hFFFF_FFFD_0000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL signed_p got %h want %h", gp,
               64'hFFFF_FFFD_0000_0000 + BIAS);
    end
    run_op(32'h0002_0000, 32'hFFFE_8000, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== 64'hFFFF_FFFD_0000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL signed_swap_p got %h want %h", gp,
               64'hFFFF_FFFD_0000_0000 + BIAS);
    end
  endtask

  task automatic test_extremes;
    logic [63:0] gp;
    int lat;
    out_ready = 1'b1;
    run_op(32'h8000_0000, 32'h8000_0000, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== 64'h4000_0000_0000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL min_min_p got %h want %h", gp,
               64'h4000_0000_0000_0000 + BIAS);
    end
    run_op(32'h8000_0000, 32'h7FFF_FFFF, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== 64'hC000_0000_8000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL min_max_p got %h want %h", gp,
               64'hC000_0000_8000_0000 + BIAS);
    end
    run_op(32'h0000_0000, 32'h8000_0000, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== 64'h0 + BIAS) begin
      n_fail++;
      $display("FAIL zero_p got %h want %h", gp, BIAS);
    end
    n_checks++;
    if (lat != 32) begin
      n_fail++;
      $display("FAIL zero_latency got %0d want 32", lat);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] gp;
    int lat;
    int bad;
    out_ready = 1'b0;
    run_op(32'h0001_0000, 32'h0003_0000, gp, lat);
    n_checks++;
    if (gp !== 64'h0000_0003_0000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL bp_p got %h want %h", gp,
               64'h0000_0003_0000_0000 + BIAS);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge c);
      in_valid = i[0];
      a        = 32'h0007_0000;
      b        = 32'h0005_0000;
      @(posedge c);
      #1;
      if (out_valid !== 1'b1 || p !== gp || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold bad cycles %0d want 0 (ov %b rdy %b p %h)",
               bad, out_valid, in_ready, p);
    end
    @(negedge c);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge c);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release out_valid %b in_ready %b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midop;
    logic [63:0] gp;
    int lat;
    int seen;
    out_ready = 1'b1;
    @(negedge c);
    a        = 32'h0004_0000;
    b        = 32'h0004_0000;
    in_valid = 1'b1;
    @(posedge c);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge c);
    #3;
    r_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async out_valid %b in_ready %b want 0 1",
               out_valid, in_ready);
    end
    repeat (2) @(negedge c);
    r_n  = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge c);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrst_no_output out_valid cycles %0d want 0", seen);
    end
    run_op(32'h0003_0000, 32'h0000_8000, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== 64'h0000_0001_8000_0000 + BIAS) begin
      n_fail++;
      $display("FAIL midrst_next_p got %h want %h", gp,
               64'h0000_0001_8000_0000 + BIAS);
    end
  endtask

  task automatic test_rounding;
    logic [63:0] gp;
    logic [63:0] exp_p;
    int lat;
`ifdef FMUL_Q16_ROUND_EN
    exp_p = 64'h0000_0000_0001_0000;
`else
    exp_p = 64'h0000_0000_0000_8000;
`endif
    out_ready = 1'b1;
    run_op(32'h0000_0001, 32'h0000_8000, gp, lat);
    finish_op();
    n_checks++;
    if (gp !== exp_p) begin
      n_fail++;
      $display("FAIL round_p got %h want %h", gp, exp_p);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unity();
    test_signed();
    test_extremes();
    test_backpressure();
    test_reset_midop();
    test_rounding();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
